pipe_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline. It drives the enable and active-low clear inputs of the PC register and the four stage registers: if_ff (IF/ID), id_ff (ID/EX), ex_ff (EX/MEM) and mem_ff (MEM/WB). It resolves load-use hazards, taken-branch flushes, multi-cycle LSU waits with a timeout, and a post-reset bubble window. It also keeps stall and flush performance counters.

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_hazard_ctrl_if.sv | 50 +++++
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_pkg: shared types for the pipeline stall/flush sequencer.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pipe_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic enable;
    logic reset_n;
  } stage_ctrl_t;

  localparam stage_ctrl_t C_STAGE_RUN  = 2'b11;
  localparam stage_ctrl_t C_STAGE_HOLD = 2'b00;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_hazard_ctrl_if: hazard fields in, stage register controls out.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       i_rs1_addr_id;
  logic [4:0]       i_rs2_addr_id;
  logic             i_rs1_used_id;
  logic             i_rs2_used_id;
  logic [4:0]       i_rd_addr_ex;
  logic             i_rd_wren_ex;
  logic             i_mem_rden_ex;
  logic             i_pc_sel_ex;
  logic             i_lsu_req_mem;
  logic             i_lsu_ack;
  logic             o_enable_pc;
  logic             o_enable_if;
  logic             o_enable_id;
  logic             o_enable_ex;
  logic             o_enable_mem;
  logic             o_reset_if;
  logic             o_reset_id;
  logic             o_reset_ex;
  logic             o_reset_mem;
  logic             o_timeout;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  modport master (
    output i_rs1_addr_id, i_rs2_addr_id, i_rs1_used_id, i_rs2_used_id,
    output i_rd_addr_ex, i_rd_wren_ex, i_mem_rden_ex, i_pc_sel_ex,
    output i_lsu_req_mem, i_lsu_ack,
    input  o_enable_pc, o_enable_if, o_enable_id, o_enable_ex, o_enable_mem,
    input  o_reset_if, o_reset_id, o_reset_ex, o_reset_mem,
    input  o_timeout, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_rs1_addr_id, i_rs2_addr_id, i_rs1_used_id, i_rs2_used_id,
    input  i_rd_addr_ex, i_rd_wren_ex, i_mem_rden_ex, i_pc_sel_ex,
    input  i_lsu_req_mem, i_lsu_ack,
    output o_enable_pc, o_enable_if, o_enable_id, o_enable_ex, o_enable_mem,
    output o_reset_if, o_reset_id, o_reset_ex, o_reset_mem,
    output o_timeout, o_stall_cnt, o_flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hazard_detect: combinational load-use detector on the ID/EX fields.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hazard_detect (
  input  wire logic [4:0] i_rs1_addr_id,
  input  wire logic [4:0] i_rs2_addr_id,
  input  wire logic       i_rs1_used_id,
  input  wire logic       i_rs2_used_id,
  input  wire logic [4:0] i_rd_addr_ex,
  input  wire logic       i_rd_wren_ex,
  input  wire logic       i_mem_rden_ex,
  output logic            o_load_use
);
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = i_rs1_used_id && (i_rs1_addr_id == i_rd_addr_ex);
  assign w_rs2_hit  = i_rs2_used_id && (i_rs2_addr_id == i_rd_addr_ex);
  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign o_load_use = i_mem_rden_ex && i_rd_wren_ex && (i_rd_addr_ex != 5'd0)
                      && (w_rs1_hit || w_rs2_hit);
endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int WAIT_MAX    = 16,
  parameter int CNT_W       = 32
) (
  input  wire logic         i_clk,
  input  wire logic         i_reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES + 1) : 1;
  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

  ctrl_state_e        state_q, state_d;
  logic [BOOT_W-1:0]  boot_cnt_q, boot_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [CNT_W-1:0]   flush_cnt_q;

  logic        load_use;
  logic        en_pc_d;
  stage_ctrl_t st_if_d, st_id_d, st_ex_d, st_mem_d;
  logic        timeout_d;
  logic        freeze_d, apply_d, discard_d;
  logic        stall_inc_d, flush_inc_d;

  hazard_detect u_hazard_detect (
    .i_rs1_addr_id (bus.i_rs1_addr_id),
    .i_rs2_addr_id (bus.i_rs2_addr_id),
    .i_rs1_used_id (bus.i_rs1_used_id),
    .i_rs2_used_id (bus.i_rs2_used_id),
    .i_rd_addr_ex  (bus.i_rd_addr_ex),
    .i_rd_wren_ex  (bus.i_rd_wren_ex),
    .i_mem_rden_ex (bus.i_mem_rden_ex),
    .o_load_use    (load_use)
  );

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    en_pc_d     = 1'b1;
    st_if_d     = C_STAGE_RUN;
    st_id_d     = C_STAGE_RUN;
    st_ex_d     = C_STAGE_RUN;
    st_mem_d    = C_STAGE_RUN;
    timeout_d   = 1'b0;
    freeze_d    = 1'b0;
    apply_d     = 1'b0;
    discard_d   = 1'b0;
    flush_inc_d = 1'b0;
    stall_inc_d = 1'b0;

    case (state_q)
      BOOT: begin
        en_pc_d  = 1'b0;
        st_if_d  = C_STAGE_HOLD;
        st_id_d  = C_STAGE_HOLD;
        st_ex_d  = C_STAGE_HOLD;
        st_mem_d = C_STAGE_HOLD;
        if (int'(boot_cnt_q) + 1 >= BOOT_CYCLES) begin
          state_d    = RUN;
          boot_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + BOOT_W'(1);
        end
      end
      RUN: begin
        if (bus.i_lsu_req_mem && !bus.i_lsu_ack) begin
          freeze_d   = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          apply_d = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.i_lsu_ack) begin
          apply_d    = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (int'(wait_cnt_q) >= WAIT_MAX) begin
          apply_d    = 1'b1;
          discard_d  = 1'b1;
          timeout_d  = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          freeze_d   = 1'b1;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = BOOT;
    endcase

    // Freeze holds the front of the pipe and drains a bubble into WB.
    if (freeze_d) begin
      en_pc_d          = 1'b0;
      st_if_d.enable   = 1'b0;
      st_id_d.enable   = 1'b0;
      st_ex_d.enable   = 1'b0;
      st_mem_d.reset_n = 1'b0;
    end

    // A taken branch flushes ID, which makes any load-use stall moot.
    if (apply_d) begin
      if (bus.i_pc_sel_ex) begin
        st_if_d.reset_n = 1'b0;
        st_id_d.reset_n = 1'b0;
        flush_inc_d     = 1'b1;
      end else if (load_use) begin
        en_pc_d         = 1'b0;
        st_if_d.enable  = 1'b0;
        st_id_d.reset_n = 1'b0;
      end
    end

    if (discard_d) begin
      st_mem_d.reset_n = 1'b0;
    end

    stall_inc_d = (state_q != BOOT) && !en_pc_d;

    if (i_reset) begin
      state_d     = BOOT;
      boot_cnt_d  = '0;
      wait_cnt_d  = '0;
      en_pc_d     = 1'b0;
      st_if_d     = C_STAGE_HOLD;
      st_id_d     = C_STAGE_HOLD;
      st_ex_d     = C_STAGE_HOLD;
      st_mem_d    = C_STAGE_HOLD;
      timeout_d   = 1'b0;
      stall_inc_d = 1'b0;
      flush_inc_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= BOOT;
      boot_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_q + CNT_W'(stall_inc_d);
      flush_cnt_q <= flush_cnt_q + CNT_W'(flush_inc_d);
    end
  end

  assign bus.o_enable_pc  = en_pc_d;
  assign bus.o_enable_if  = st_if_d.enable;
  assign bus.o_enable_id  = st_id_d.enable;
  assign bus.o_enable_ex  = st_ex_d.enable;
  assign bus.o_enable_mem = st_mem_d.enable;
  assign bus.o_reset_if   = st_if_d.reset_n;
  assign bus.o_reset_id   = st_id_d.reset_n;
  assign bus.o_reset_ex   = st_ex_d.reset_n;
  assign bus.o_reset_mem  = st_mem_d.reset_n;
  assign bus.o_timeout    = timeout_d;
  assign bus.o_stall_cnt  = stall_cnt_q;
  assign bus.o_flush_cnt  = flush_cnt_q;
endmodule
`default_nettype wire
